// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: writeback write port, decode read ports and the clear-engine handshake.
// The master side drives requests and addresses; the slave side (the register file) returns ack, data and status.
interface regfile_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                wr_ack;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  wr_ack, rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output wr_ack, rd_data, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised RV32I integer register file: registered reads, write-ack pulse, sequential clear engine.
// Optional macro REGFILE_BYPASS_EN selects write-first reads (default: read-old, pipeline stalls on RAW).
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  regfile_param_if.slave    bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;

  // Index 0 is hardwired zero, so it has no storage.
  logic [XLEN-1:0]     regs_q [1:NREGS-1];

  logic                wr_fire;
  logic                wr_hit;
  logic                clr_zero;
  logic                wr_ack_d, wr_ack_q;
  logic                clr_busy_d, clr_busy_q;
  logic                clr_done_d, clr_done_q;
  logic [NRD*XLEN-1:0] rd_data_d, rd_data_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clr_idx_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = AW'(1);
        end
      end
      CLEAR: begin
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d   = IDLE;
          clr_idx_d = AW'(1);
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = AW'(1);
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (clear wins over a simultaneous write request)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_fire    = (state_q == IDLE) && bus.wr_en && !bus.clr_req;
    clr_zero   = (state_q == CLEAR);
    wr_ack_d   = wr_fire;
    clr_busy_d = (state_d == CLEAR);
    clr_done_d = (state_q == CLEAR) && (state_d == IDLE);
  end

  // A fired write only lands when the index names real storage (1..NREGS-1).
  always_comb begin
    wr_hit = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.wr_addr == AW'(r)) wr_hit = wr_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  // NOTE: the array is reset because the file must read as all-zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (clr_zero && (clr_idx_q == AW'(r))) begin
          regs_q[r] <= '0;
        end else if (wr_hit && (bus.wr_addr == AW'(r))) begin
          regs_q[r] <= bus.wr_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: unmatched indices (0 or >= NREGS) fall through to zero
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (bus.rd_addr[p*AW +: AW] == AW'(r)) rd_data_d[p*XLEN +: XLEN] = regs_q[r];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (bus.rd_addr[p*AW +: AW] == bus.wr_addr)) begin
        rd_data_d[p*XLEN +: XLEN] = bus.wr_data;
      end
      if (clr_zero && (bus.rd_addr[p*AW +: AW] == clr_idx_q)) begin
        rd_data_d[p*XLEN +: XLEN] = '0;
      end
`else
      // Read-old: same-edge writes and clears become visible one cycle later.
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output flops: every output comes straight from a reset flop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ack_q   <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr_ack   = wr_ack_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table plus hand-written reset and clear sequences.
// Expected values follow the read-old or write-first behaviour selected by REGFILE_BYPASS_EN.
module tb_regfile_param;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_param_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rd0;
    logic [AW-1:0]   rd1;
    logic            exp_ack;
    logic [XLEN-1:0] exp_rd0;
    logic [XLEN-1:0] exp_rd1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic cr);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = {r1, r0};
    bus.clr_req = cr;
  endtask

  function automatic logic [XLEN-1:0] rd(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] byp(input logic [XLEN-1:0] bypassed, input logic [XLEN-1:0] old);
`ifdef REGFILE_BYPASS_EN
    return bypassed;
`else
    return old;
`endif
  endfunction

  initial begin
    int busy_cnt;
    int guard;
    logic ack_seen;
    logic both_seen;
    logic done_seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0);

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack",  {31'd0, bus.wr_ack},   32'd0);
    check("reset_busy", {31'd0, bus.clr_busy}, 32'd0);
    check("reset_done", {31'd0, bus.clr_done}, 32'd0);
    check("reset_rd0",  rd(0), 32'd0);
    rst_n = 1'b1;

    // ---------------- Async reset mid-cycle ----------------
    drive(1'b1, 5'd2, 32'h0000CAFE, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 5'd4, 32'h00000044, 5'd2, 5'd0, 1'b0);
    step();
    check("pre_rst_ack", {31'd0, bus.wr_ack}, 32'd1);
    check("pre_rst_rd0", rd(0), 32'h0000CAFE);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ack",  {31'd0, bus.wr_ack},   32'd0);
    check("async_rst_rd0",  rd(0), 32'd0);
    check("async_rst_busy", {31'd0, bus.clr_busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.clr_done}, 32'd0);
    drive(1'b0, '0, '0, 5'd2, 5'd4, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_x2", rd(0), 32'd0);
    check("post_rst_x4", rd(1), 32'd0);

    // ---------------- Directed vector table ----------------
    vecs[0]  = '{"wr_x5",        1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  1'b1, 32'd0, 32'd0};
    vecs[1]  = '{"rd_x5_x0",     1'b0, 5'd0,  32'd0,        5'd5,  5'd0,  1'b0, 32'hDEADBEEF, 32'd0};
    vecs[2]  = '{"wr_x0_drop",   1'b1, 5'd0,  32'h12345678, 5'd5,  5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{"rd_x0",        1'b0, 5'd0,  32'd0,        5'd0,  5'd5,  1'b0, 32'd0, 32'hDEADBEEF};
    vecs[4]  = '{"wr_x7_1",      1'b1, 5'd7,  32'h1,        5'd0,  5'd0,  1'b1, 32'd0, 32'd0};
    vecs[5]  = '{"raw_x7",       1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,  1'b1,
                 byp(32'hA5A5A5A5, 32'h1), 32'hDEADBEEF};
    vecs[6]  = '{"rd_x7_x7",     1'b0, 5'd0,  32'd0,        5'd7,  5'd7,  1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{"raw_x31",      1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  1'b1,
                 byp(32'hFFFFFFFF, 32'd0), 32'd0};
    vecs[8]  = '{"rd_x31_x30",   1'b0, 5'd0,  32'd0,        5'd31, 5'd30, 1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[9]  = '{"raw_x1_port1", 1'b1, 5'd1,  32'h13579BDF, 5'd31, 5'd1,  1'b1,
                 32'hFFFFFFFF, byp(32'h13579BDF, 32'd0)};
    vecs[10] = '{"rd_x1_x7",     1'b0, 5'd0,  32'd0,        5'd1,  5'd7,  1'b0, 32'h13579BDF, 32'hA5A5A5A5};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].rd0, vecs[i].rd1, 1'b0);
      step();
      check({vecs[i].name, "_ack"}, {31'd0, bus.wr_ack}, {31'd0, vecs[i].exp_ack});
      check({vecs[i].name, "_rd0"}, rd(0), vecs[i].exp_rd0);
      check({vecs[i].name, "_rd1"}, rd(1), vecs[i].exp_rd1);
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    step();
    check("ack_single_pulse", {31'd0, bus.wr_ack}, 32'd0);

    // ---------------- Sequential clear ----------------
    for (int r = 1; r < NREGS; r++) begin
      drive(1'b1, AW'(r), XLEN'(r), '0, '0, 1'b0);
      step();
    end
    // Clear request with a simultaneous write to x3: clear wins.
    drive(1'b1, 5'd3, 32'h00000BAD, 5'd3, 5'd9, 1'b1);
    step();
    check("clr_start_ack",  {31'd0, bus.wr_ack},   32'd0);
    check("clr_start_busy", {31'd0, bus.clr_busy}, 32'd1);
    check("clr_start_rd0",  rd(0), 32'd3);
    busy_cnt  = bus.clr_busy ? 1 : 0;
    ack_seen  = 1'b0;
    both_seen = 1'b0;
    // First CLEAR cycle zeroes x1; x3 must still hold its fill value.
    drive(1'b1, 5'd1, 32'h00000077, 5'd1, 5'd3, 1'b0);
    step();
    check("clr_c1_rd_x1", rd(0), byp(32'd0, 32'd1));
    check("clr_c1_rd_x3", rd(1), 32'd3);
    if (bus.clr_busy) busy_cnt++;
    if (bus.wr_ack) ack_seen = 1'b1;
    guard = 0;
    while (bus.clr_busy && guard < 100) begin
      drive(1'b1, 5'd1, 32'h00000077, 5'd31, 5'd1, guard == 5);
      step();
      guard++;
      if (bus.clr_busy) busy_cnt++;
      if (bus.wr_ack) ack_seen = 1'b1;
      if (bus.clr_busy && bus.clr_done) both_seen = 1'b1;
    end
    check("clr_timeout",    {31'd0, guard >= 100}, 32'd0);
    check("clr_busy_cycles", busy_cnt, 32'd31);
    check("clr_done_pulse", {31'd0, bus.clr_done}, 32'd1);
    check("clr_no_ack",     {31'd0, ack_seen},  32'd0);
    check("clr_busy_done_overlap", {31'd0, both_seen}, 32'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    step();
    check("clr_done_one_cycle", {31'd0, bus.clr_done}, 32'd0);
    check("clr_no_restart",     {31'd0, bus.clr_busy}, 32'd0);
    for (int r = 1; r < NREGS; r += 2) begin
      drive(1'b0, '0, '0, AW'(r), AW'(r + 1), 1'b0);
      step();
      check($sformatf("clr_zero_x%0d", r), rd(0), 32'd0);
      check($sformatf("clr_zero_x%0d", (r + 1) % 32), rd(1), 32'd0);
    end

    // ---------------- Reset in the middle of a clear ----------------
    drive(1'b1, 5'd9, 32'h00001234, '0, '0, 1'b0);
    step();
    drive(1'b1, 5'd20, 32'h00000099, '0, '0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    repeat (9) step();
    check("mid_clr_busy", {31'd0, bus.clr_busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_clr_rst_busy", {31'd0, bus.clr_busy}, 32'd0);
    check("mid_clr_rst_done", {31'd0, bus.clr_done}, 32'd0);
    step();
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.clr_done || bus.clr_busy) done_seen = 1'b1;
    end
    check("mid_clr_no_done", {31'd0, done_seen}, 32'd0);
    drive(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd20, 1'b0);
    step();
    check("mid_clr_wr_ack", {31'd0, bus.wr_ack}, 32'd1);
    check("mid_clr_x20",    rd(1), 32'd0);
    drive(1'b0, '0, '0, 5'd9, 5'd20, 1'b0);
    step();
    check("mid_clr_x9",     rd(0), 32'h00000055);
    check("mid_clr_x20_b",  rd(1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
